// File: rtl/slc3_mem_responder_if.sv
// CPU-side bus between the SLC-3 controller and the memory responder:
// level strobes, address/data in, registered read data and completion pulses.
interface slc3_mem_responder_if;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Rd_Valid;
    logic        Wr_Done;
    logic        Busy;

    modport master (
        output Mem_OE, Mem_WE, ADDR, Data_from_CPU,
        input  Data_to_CPU, Rd_Valid, Wr_Done, Busy
    );

    modport slave (
        input  Mem_OE, Mem_WE, ADDR, Data_from_CPU,
        output Data_to_CPU, Rd_Valid, Wr_Done, Busy
    );
endinterface

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC-3: wait-stated async SRAM accesses plus one
// memory-mapped I/O word (Switches on read, HEX_Reg on write), with completion pulses.
module slc3_mem_responder #(
    parameter int          RD_WAIT  = 1,
    parameter int          WR_PULSE = 2,
    parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    slc3_mem_responder_if.slave   cpu,
    input  logic [15:0]           Switches,
    output logic [15:0]           HEX_Reg,
    output logic [19:0]           SRAM_ADDR,
    input  logic [15:0]           SRAM_DQ_in,
    output logic [15:0]           SRAM_DQ_out,
    output logic                  SRAM_DQ_oe,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_RECOVER, S_DONE_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [15:0] dout_q, dout_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] dq_q, dq_d;
    logic [19:0] addr_q, addr_d;
    logic        rd_valid_q, rd_valid_d;
    logic        wr_done_q, wr_done_d;
    logic        busy_q, busy_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        dout_d  = dout_q;
        hex_d   = hex_q;
        dq_d    = dq_q;
        addr_d  = addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (cpu.Mem_WE || cpu.Mem_OE) begin
                    // Write wins when both strobes are high.
                    is_wr_d = cpu.Mem_WE;
                    if (cpu.ADDR == IO_ADDR) begin
                        if (cpu.Mem_WE) hex_d  = cpu.Data_from_CPU;
                        else            dout_d = Switches;
                        state_d = S_DONE_HOLD;
                    end else begin
                        addr_d = {4'b0, cpu.ADDR};
                        if (cpu.Mem_WE) begin
                            dq_d    = cpu.Data_from_CPU;
                            state_d = S_WR_SETUP;
                        end else begin
                            cnt_d   = 16'(RD_WAIT);
                            state_d = S_RD_WAIT;
                        end
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 16'd1) begin
                    dout_d  = SRAM_DQ_in;
                    state_d = S_DONE_HOLD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_WR_SETUP: begin
                cnt_d   = 16'(WR_PULSE);
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_q == 16'd1) state_d = S_WR_RECOVER;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_WR_RECOVER: state_d = S_DONE_HOLD;
            S_DONE_HOLD: begin
                // Wait for both strobes to drop so one strobe level is one access.
                if (!cpu.Mem_OE && !cpu.Mem_WE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        rd_valid_d = (state_d == S_DONE_HOLD) && (state_q != S_DONE_HOLD) && !is_wr_d;
        wr_done_d  = (state_d == S_DONE_HOLD) && (state_q != S_DONE_HOLD) &&  is_wr_d;
        busy_d     = (state_d != S_IDLE);
        ce_n_d     = !(state_d inside {S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_RECOVER});
        oe_n_d     = (state_d != S_RD_WAIT);
        we_n_d     = (state_d != S_WR_PULSE);
        dq_oe_d    = (state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_RECOVER});
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_wr_q    <= 1'b0;
            dout_q     <= '0;
            hex_q      <= '0;
            dq_q       <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_wr_q    <= is_wr_d;
            dout_q     <= dout_d;
            hex_q      <= hex_d;
            dq_q       <= dq_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
            busy_q     <= busy_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign cpu.Data_to_CPU = dout_q;
    assign cpu.Rd_Valid    = rd_valid_q;
    assign cpu.Wr_Done     = wr_done_q;
    assign cpu.Busy        = busy_q;
    assign HEX_Reg         = hex_q;
    assign SRAM_ADDR       = addr_q;
    assign SRAM_DQ_out     = dq_q;
    assign SRAM_DQ_oe      = dq_oe_q;
    assign SRAM_CE_N       = ce_n_q;
    assign SRAM_OE_N       = oe_n_q;
    assign SRAM_WE_N       = we_n_q;
    // Always full-word accesses: byte lanes follow chip enable.
    assign SRAM_UB_N       = ce_n_q;
    assign SRAM_LB_N       = ce_n_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Scoreboard bench for slc3_mem_responder: a driver issues accesses and queues the
// expected outcome; a negedge monitor compares at every completion pulse.
module tb_slc3_mem_responder;
    localparam int          RDW = 1;
    localparam int          WRP = 2;
    localparam logic [15:0] IOA = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] HEX_Reg;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in, SRAM_DQ_out;
    logic        SRAM_DQ_oe, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    slc3_mem_responder_if cpu();

    slc3_mem_responder #(.RD_WAIT(RDW), .WR_PULSE(WRP), .IO_ADDR(IOA)) dut (
        .Clk(Clk), .Reset(Reset), .cpu(cpu), .Switches(Switches), .HEX_Reg(HEX_Reg),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'h1234;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Async SRAM model (256 words); a write lands at each clock it sees WE_N low.
    logic [15:0] sram [0:255];
    logic        preload = 1'b1;
    always @(posedge Clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
        end else if (!SRAM_CE_N && !SRAM_WE_N) begin
            sram[SRAM_ADDR[7:0]] <= SRAM_DQ_oe ? SRAM_DQ_out : 16'hBAD0;
        end
    end
    assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[7:0]] : 16'hDEAD;

    // Reference model state
    logic [15:0] ref_mem [0:255];
    logic [15:0] m_dout = '0;
    logic [15:0] m_hex  = '0;

    typedef struct {
        bit          is_wr;
        bit          is_io;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] dout;
        logic [15:0] hex;
        int          exp_cyc;
        int          n_oe, n_we, n_dqoe, n_ce;
    } item_t;
    item_t sbq[$];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic check_reset_state();
        chk("rst_dout",   cpu.Data_to_CPU, 16'h0);
        chk("rst_hex",    HEX_Reg, 16'h0);
        chk("rst_addr",   SRAM_ADDR, 20'h0);
        chk("rst_dq_out", SRAM_DQ_out, 16'h0);
        chk("rst_pulses", {cpu.Rd_Valid, cpu.Wr_Done, cpu.Busy, SRAM_DQ_oe}, 4'b0000);
        chk("rst_n_ctl",  {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu.Busy && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("busy_timeout", cpu.Busy, 1'b0);
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [15:0] a,
                             input logic [15:0] d, input int extra);
        item_t it;
        int    lat;
        logic [15:0] sw;
        sw       = 16'($urandom);
        Switches = sw;
        it.is_wr = wr;
        it.is_io = (a == IOA);
        it.addr  = a;
        it.wdata = d;
        if (it.is_io)    lat = 1;
        else if (wr)     lat = WRP + 3;
        else             lat = RDW + 1;
        if (wr) begin
            if (it.is_io) m_hex = d;
            else          ref_mem[a[7:0]] = d;
        end else begin
            m_dout = it.is_io ? sw : ref_mem[a[7:0]];
        end
        it.dout    = m_dout;
        it.hex     = m_hex;
        it.exp_cyc = cyc + lat;
        it.n_oe    = (!wr && !it.is_io) ? RDW : 0;
        it.n_we    = (wr && !it.is_io) ? WRP : 0;
        it.n_dqoe  = (wr && !it.is_io) ? WRP + 2 : 0;
        it.n_ce    = it.is_io ? 0 : (wr ? WRP + 2 : RDW);
        sbq.push_back(it);
        cpu.Mem_OE = rd;
        cpu.Mem_WE = wr;
        cpu.ADDR = a;
        cpu.Data_from_CPU = d;
        repeat (lat + 1 + extra) begin
            @(posedge Clk); #1;
            cpu.ADDR = 16'($urandom);
            cpu.Data_from_CPU = 16'($urandom);
            Switches = 16'($urandom);
        end
        cpu.Mem_OE = 1'b0;
        cpu.Mem_WE = 1'b0;
        wait_idle();
        repeat ($urandom_range(0, 2)) @(posedge Clk);
        #1;
    endtask

    // Monitor: accumulates strobe cycles per access and checks at each completion pulse.
    initial begin
        int c_oe, c_we, c_dqoe, c_ce, c_ub, c_lb;
        item_t it;
        c_oe = 0; c_we = 0; c_dqoe = 0; c_ce = 0; c_ub = 0; c_lb = 0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                c_oe = 0; c_we = 0; c_dqoe = 0; c_ce = 0; c_ub = 0; c_lb = 0;
            end else begin
                c_oe   += int'(!SRAM_OE_N);
                c_we   += int'(!SRAM_WE_N);
                c_dqoe += int'(SRAM_DQ_oe);
                c_ce   += int'(!SRAM_CE_N);
                c_ub   += int'(!SRAM_UB_N);
                c_lb   += int'(!SRAM_LB_N);
                if (cpu.Rd_Valid || cpu.Wr_Done) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL spurious_pulse: actual rd=%0b wr=%0b required none",
                                 cpu.Rd_Valid, cpu.Wr_Done);
                    end else begin
                        it = sbq.pop_front();
                        chk("rd_valid",   cpu.Rd_Valid, !it.is_wr);
                        chk("wr_done",    cpu.Wr_Done, it.is_wr);
                        chk("latency",    cyc, it.exp_cyc);
                        chk("dout",       cpu.Data_to_CPU, it.dout);
                        chk("hex",        HEX_Reg, it.hex);
                        chk("oe_cycles",  c_oe, it.n_oe);
                        chk("we_cycles",  c_we, it.n_we);
                        chk("dqoe_cycles", c_dqoe, it.n_dqoe);
                        chk("ce_cycles",  c_ce, it.n_ce);
                        chk("ublb_cycles", {c_ub[15:0], c_lb[15:0]}, {it.n_ce[15:0], it.n_ce[15:0]});
                        if (!it.is_io) chk("sram_addr", SRAM_ADDR, {4'b0, it.addr});
                        if (it.is_wr && !it.is_io) chk("sram_mem", sram[it.addr[7:0]], it.wdata);
                    end
                    c_oe = 0; c_we = 0; c_dqoe = 0; c_ce = 0; c_ub = 0; c_lb = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d;
        int k;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        Reset = 1'b1;
        cpu.Mem_OE = 1'b0;
        cpu.Mem_WE = 1'b0;
        cpu.ADDR = '0;
        cpu.Data_from_CPU = '0;
        Switches = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_state();
        preload = 1'b0;
        Reset = 1'b0;
        @(posedge Clk); #1;
        check_reset_state();

        // Directed: plain read, write + readback, I/O read/write, simultaneous strobes
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 2);
        do_access(1'b0, 1'b1, 16'h0020, 16'hBEEF, 0);
        do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 1);
        do_access(1'b1, 1'b0, IOA,      16'h0000, 0);
        do_access(1'b0, 1'b1, IOA,      16'h0042, 0);
        do_access(1'b1, 1'b1, 16'h0030, 16'h5555, 1);
        do_access(1'b1, 1'b0, 16'h0030, 16'h0000, 0);

        // Reset in the second WE-low cycle of a write aborts it cleanly
        cpu.Mem_WE = 1'b1;
        cpu.ADDR = 16'h0050;
        cpu.Data_from_CPU = 16'h7777;
        repeat (3) @(posedge Clk);
        #1;
        chk("t5_we_low", SRAM_WE_N, 1'b0);
        Reset = 1'b1;
        cpu.Mem_WE = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk("t5_we_n",  SRAM_WE_N, 1'b1);
        chk("t5_ce_n",  SRAM_CE_N, 1'b1);
        chk("t5_dq_oe", SRAM_DQ_oe, 1'b0);
        chk("t5_busy",  cpu.Busy, 1'b0);
        chk("t5_hex",   HEX_Reg, 16'h0);
        m_hex = '0;
        m_dout = '0;
        ref_mem[8'h50] = 16'h7777;
        do_access(1'b1, 1'b0, 16'h0050, 16'h0000, 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 3);
            a = ($urandom_range(0, 4) == 0) ? IOA : 16'($urandom_range(0, 255));
            d = 16'($urandom);
            do_access(k != 1, k == 1 || k == 2, a, d, $urandom_range(0, 3));
        end

        repeat (5) @(posedge Clk);
        #1;
        chk("queue_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
